dmem_copy_ctrl: RTL and testbench
=================================

// Module: dmem_copy_ctrl
// PURPOSE
//  Block-copy engine and port arbiter for the single-port 8-bit data memory (async read, write on posedge clk).
//  Copies LEN bytes from SRC to DST, one read cycle then one write cycle per byte.
//  Shares the memory port with the CPU load/store path; the CPU wins by default,
//  with a bounded-starvation override. Sits between the CPU datapath and data memory.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive engine-blocked cycles before the engine is forced a grant; 0 = CPU absolute priority
// PORTS
//  clk          in   1  system clock
//  Reset        in   1  synchronous, active-high reset
//  start        in   1  launch copy; sampled only in IDLE
//  abort        in   1  cancel copy in progress
//  src_addr     in   8  first source address
//  dst_addr     in   8  first destination address
//  length       in   8  byte count; 0 = no-op
//  busy         out  1  copy in progress
//  done         out  1  one-cycle pulse on normal completion
//  cpu_req      in   1  CPU wants the memory port this cycle
//  cpu_we       in   1  CPU write (1) / read (0)
//  cpu_addr     in   8  CPU address
//  cpu_wdata    in   8  CPU write data
//  cpu_rdata    out  8  = mem_rdata, always
//  cpu_wait     out  1  CPU denied this cycle; CPU holds request and retries
//  mem_addr     out  8  to data memory DataAddress
//  mem_read     out  1  to ReadMem
//  mem_write    out  1  to WriteMem
//  mem_wdata    out  8  to DataIn
//  mem_rdata    in   8  from DataOut (combinational)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, stall_cnt=0, held regs=0. Outputs follow the mux below, so mem_write=0 unless cpu_req&cpu_we.
//  FSM IDLE/RD/WR; all state, regs and done are registered.
//   IDLE: start & length!=0 -> latch src,dst,cnt=length; RD next.
//         start & length==0 -> done=1 next cycle; stay IDLE.
//   RD (granted): mem_addr=src, mem_read=1; hold<=mem_rdata; src<=src+1; -> WR.
//   WR (granted): mem_addr=dst, mem_write=1, mem_wdata=hold; dst<=dst+1; cnt<=cnt-1.
//         cnt==1 -> IDLE, done=1 next cycle; else -> RD.
//   Not granted: state, src, dst, cnt, hold unchanged; no engine mem access.
//  busy=1 in RD and WR, 0 in IDLE; busy and done never high together.
//  Arbitration, combinational per cycle; eng_want = state in {RD,WR}:
//   eng_grant = eng_want & (~cpu_req | (STARVE_LIMIT!=0 & stall_cnt==STARVE_LIMIT)).
//   cpu_wait = cpu_req & eng_grant. Otherwise a CPU request drives mem_* directly:
//   mem_read=~cpu_we, mem_write=cpu_we. No request: mem_read=mem_write=0.
//   stall_cnt: +1 when eng_want & cpu_req & ~eng_grant; cleared on eng_grant or IDLE.
//  Timing, no contention: start at cycle t, length N -> busy t+1..t+2N, done at t+2N+1.
//  Addresses wrap modulo 256; 0xFF+1 = 0x00.
//  Forward byte-by-byte copy; overlapping regions are defined by that order (dst=src+1 replicates byte).
//  abort in RD/WR: no engine access that cycle; -> IDLE; no done pulse. Writes already done stay.
//  abort in IDLE: no effect; abort and start together in IDLE: abort wins.
//  start while busy: ignored.
//  Reset mid-copy -> IDLE immediately; a pending write is not performed.
// STRUCTURE
//  mem_pkg: addr_t, data_t (logic [7:0]), enum copy_state_t {IDLE,RD,WR}, STARVE_LIMIT default.
//  One sub-module, dmem_port_arb: stall counter, eng_grant/cpu_wait, mem_* mux. Top holds FSM + datapath regs.
// TESTING
//  1 src=0x10,dst=0x40,len=4, mem[0x10..13]=A1..A4, no CPU -> mem[0x40..43]=A1..A4; busy 8 cycles; done at t+9.
//  2 len=0 -> done at t+1; busy never 1; no mem_write.
//  3 src=0xFE,dst=0xFF,len=3, mem[FE,FF,00]=11,22,33 -> forward overlap: each write replicates the prior write (dst=src+1 case);
//    final mem[FF]=11, mem[00]=11, mem[01]=11; addresses wrap.
//  4 cpu_req held high during copy, STARVE_LIMIT=4 -> engine granted every 5th cycle; cpu_wait pulses there; copy still completes.
//  5 STARVE_LIMIT=0, cpu_req high 20 cycles -> engine frozen, cpu_wait=0; resumes after release; data correct.
//  6 abort in WR of byte 2 of 4 -> only byte 1 written, busy=0 next cycle, no done; Reset mid-copy -> same, all outputs at reset values.

Source files
------------

// File: rtl/dmem_copy_ctrl_pkg.sv
// dmem_copy_ctrl_pkg: shared types and defaults for the data-memory block-copy engine
package dmem_copy_ctrl_pkg;
  typedef logic [7:0] addr_t;
  typedef logic [7:0] data_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} copy_state_t;
  localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/dmem_copy_ctrl_if.sv
// dmem_copy_ctrl_if: copy-control, CPU load/store and data-memory port bundle
interface dmem_copy_ctrl_if;
  import dmem_copy_ctrl_pkg::*;
  logic  start;
  logic  abort;
  addr_t src_addr;
  addr_t dst_addr;
  logic [7:0] length;
  logic  busy;
  logic  done;
  logic  cpu_req;
  logic  cpu_we;
  addr_t cpu_addr;
  data_t cpu_wdata;
  data_t cpu_rdata;
  logic  cpu_wait;
  addr_t mem_addr;
  logic  mem_read;
  logic  mem_write;
  data_t mem_wdata;
  data_t mem_rdata;
  modport slave (
    input  start, abort, src_addr, dst_addr, length,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output busy, done, cpu_rdata, cpu_wait,
    output mem_addr, mem_read, mem_write, mem_wdata
  );
  modport master (
    output start, abort, src_addr, dst_addr, length,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  busy, done, cpu_rdata, cpu_wait,
    input  mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/dmem_copy_ctrl_port_arb.sv
// dmem_port_arb: shares the data-memory port between the CPU and the copy engine with bounded starvation
module dmem_port_arb
  import dmem_copy_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_eng_want,
  input  logic  i_eng_wr,
  input  addr_t i_eng_addr,
  input  data_t i_eng_wdata,
  input  logic  i_cpu_req,
  input  logic  i_cpu_we,
  input  addr_t i_cpu_addr,
  input  data_t i_cpu_wdata,
  output logic  o_eng_grant,
  output logic  o_cpu_wait,
  output addr_t o_mem_addr,
  output logic  o_mem_read,
  output logic  o_mem_write,
  output data_t o_mem_wdata
);
  logic [7:0] r_stall;
  logic       w_force;
  assign w_force     = (STARVE_LIMIT != 0) && (r_stall == 8'(STARVE_LIMIT));
  assign o_eng_grant = i_eng_want & (~i_cpu_req | w_force);
  assign o_cpu_wait  = i_cpu_req & o_eng_grant;
  // Granted engine owns the port; otherwise a CPU request passes straight through
  always_comb begin
    o_mem_addr  = o_eng_grant ? i_eng_addr : i_cpu_addr;
    o_mem_read  = o_eng_grant ? ~i_eng_wr : i_cpu_req & ~i_cpu_we;
    o_mem_write = o_eng_grant ? i_eng_wr : i_cpu_req & i_cpu_we;
    o_mem_wdata = o_eng_grant ? i_eng_wdata : i_cpu_wdata;
  end
  // Consecutive cycles the engine lost to the CPU; any grant or idle cycle restarts the count
  always_ff @(posedge clk)
    if (rst || !i_eng_want || o_eng_grant) r_stall <= '0;
    else r_stall <= r_stall + 8'd1;
endmodule

// File: rtl/dmem_copy_ctrl.sv
// dmem_copy_ctrl: byte-by-byte block copy engine sharing the data-memory port with the CPU
module dmem_copy_ctrl
  import dmem_copy_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic clk,
  input logic Reset,
  dmem_copy_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RD   = RD;
  localparam logic [1:0] ST_WR   = WR;
  logic [1:0] r_state;
  addr_t      r_src;
  addr_t      r_dst;
  logic [7:0] r_cnt;
  data_t      r_hold;
  logic       r_done;
  logic       w_busy;
  logic       w_eng_want;
  logic       w_eng_grant;
  assign w_busy         = r_state != ST_IDLE;
  // Abort and reset suppress the engine access so a pending write is never issued
  assign w_eng_want     = w_busy & ~bus.abort & ~Reset;
  assign bus.busy       = w_busy;
  assign bus.done       = r_done;
  assign bus.cpu_rdata  = bus.mem_rdata;
  dmem_port_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk         (clk),
    .rst         (Reset),
    .i_eng_want  (w_eng_want),
    .i_eng_wr    (r_state == ST_WR),
    .i_eng_addr  (r_state == ST_WR ? r_dst : r_src),
    .i_eng_wdata (r_hold),
    .i_cpu_req   (bus.cpu_req),
    .i_cpu_we    (bus.cpu_we),
    .i_cpu_addr  (bus.cpu_addr),
    .i_cpu_wdata (bus.cpu_wdata),
    .o_eng_grant (w_eng_grant),
    .o_cpu_wait  (bus.cpu_wait),
    .o_mem_addr  (bus.mem_addr),
    .o_mem_read  (bus.mem_read),
    .o_mem_write (bus.mem_write),
    .o_mem_wdata (bus.mem_wdata)
  );
  // Copy sequencer: alternate read and write per byte, advancing only on granted cycles
  always_ff @(posedge clk)
    if (Reset) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (bus.start && !bus.abort) begin
          if (bus.length == 8'd0) r_done <= 1'b1;
          else begin
            r_src   <= bus.src_addr;
            r_dst   <= bus.dst_addr;
            r_cnt   <= bus.length;
            r_state <= ST_RD;
          end
        end
      end else if (bus.abort) r_state <= ST_IDLE;
      else if (w_eng_grant) begin
        if (r_state == ST_RD) begin
          r_hold  <= bus.mem_rdata;
          r_src   <= r_src + 8'd1;
          r_state <= ST_WR;
        end else begin
          r_dst   <= r_dst + 8'd1;
          r_cnt   <= r_cnt - 8'd1;
          r_state <= r_cnt == 8'd1 ? ST_IDLE : ST_RD;
          r_done  <= r_cnt == 8'd1;
        end
      end
    end
endmodule

// File: tb/tb_dmem_copy_ctrl.sv
// tb_dmem_copy_ctrl: two instances (CPU absolute priority and starvation limit 4) against a transaction-level model
module tb_dmem_copy_ctrl;
  logic clk = 1'b0;
  logic rst, start, abort, cpu_req, cpu_we;
  logic [7:0] src, dst, len, cpu_addr, cpu_wdata;
  always #5 clk = ~clk;

  dmem_copy_ctrl_if b0 ();
  dmem_copy_ctrl_if b1 ();
  dmem_copy_ctrl #(.STARVE_LIMIT(0)) dut_l0 (.clk(clk), .Reset(rst), .bus(b0));
  dmem_copy_ctrl #(.STARVE_LIMIT(4)) dut_l4 (.clk(clk), .Reset(rst), .bus(b1));

  assign b0.start = start;     assign b1.start = start;
  assign b0.abort = abort;     assign b1.abort = abort;
  assign b0.src_addr = src;    assign b1.src_addr = src;
  assign b0.dst_addr = dst;    assign b1.dst_addr = dst;
  assign b0.length = len;      assign b1.length = len;
  assign b0.cpu_req = cpu_req; assign b1.cpu_req = cpu_req;
  assign b0.cpu_we = cpu_we;   assign b1.cpu_we = cpu_we;
  assign b0.cpu_addr = cpu_addr;   assign b1.cpu_addr = cpu_addr;
  assign b0.cpu_wdata = cpu_wdata; assign b1.cpu_wdata = cpu_wdata;

  // Data memories: asynchronous read, write on the rising edge
  logic [7:0] amem0 [256];
  logic [7:0] amem1 [256];
  always @(posedge clk) begin
    if (b0.mem_write) amem0[b0.mem_addr] <= b0.mem_wdata;
    if (b1.mem_write) amem1[b1.mem_addr] <= b1.mem_wdata;
  end
  assign b0.mem_rdata = amem0[b0.mem_addr];
  assign b1.mem_rdata = amem1[b1.mem_addr];

  typedef struct packed {logic busy, done, wt, rd, wr; logic [7:0] addr, wdata, rdata;} obs_t;
  obs_t o0, o1;
  assign o0 = {b0.busy, b0.done, b0.cpu_wait, b0.mem_read, b0.mem_write, b0.mem_addr, b0.mem_wdata, b0.cpu_rdata};
  assign o1 = {b1.busy, b1.done, b1.cpu_wait, b1.mem_read, b1.mem_write, b1.mem_addr, b1.mem_wdata, b1.cpu_rdata};

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference model: a copy is an ordered list of 2*len port operations (read src+i, write dst+i),
  // consumed one per cycle in which the engine wins the port.
  logic [7:0] rmem [2][256];
  bit         m_busy [2];
  bit         m_done [2];
  int         m_len [2];
  int         m_idx [2];
  int         m_stall [2];
  logic [7:0] m_src [2];
  logic [7:0] m_dst [2];
  logic [7:0] m_hold [2];

  task automatic model(input int k);
    obs_t o;
    int lim;
    bit want, grant, wop, e_rd, e_wr;
    logic [7:0] e_addr, e_wd;
    o = k ? o1 : o0;
    lim = k ? 4 : 0;
    want = m_busy[k] && !abort && !rst;
    grant = want && (!cpu_req || (lim != 0 && m_stall[k] == lim));
    wop = (m_idx[k] % 2) == 1;
    e_rd = grant ? !wop : (cpu_req && !cpu_we);
    e_wr = grant ? wop : (cpu_req && cpu_we);
    e_addr = grant ? (wop ? m_dst[k] + 8'(m_idx[k] / 2) : m_src[k] + 8'(m_idx[k] / 2)) : cpu_addr;
    e_wd = grant ? m_hold[k] : cpu_wdata;
    chk("busy", k, o.busy, m_busy[k]);
    chk("done", k, o.done, m_done[k]);
    chk("cpu_wait", k, o.wt, cpu_req && grant);
    chk("mem_read", k, o.rd, e_rd);
    chk("mem_write", k, o.wr, e_wr);
    if (e_rd || e_wr) chk("mem_addr", k, o.addr, e_addr);
    if (e_wr) chk("mem_wdata", k, o.wdata, e_wd);
    if (e_rd) chk("cpu_rdata", k, o.rdata, rmem[k][e_addr]);
    if (e_rd && grant) m_hold[k] = rmem[k][e_addr];
    if (e_wr) rmem[k][e_addr] = e_wd;
    m_stall[k] = (want && !grant) ? m_stall[k] + 1 : 0;
    m_done[k] = 1'b0;
    if (rst) m_busy[k] = 1'b0;
    else if (!m_busy[k]) begin
      if (start && !abort) begin
        if (len == 8'd0) m_done[k] = 1'b1;
        else begin
          m_busy[k] = 1'b1;
          m_src[k] = src;
          m_dst[k] = dst;
          m_len[k] = int'(len);
          m_idx[k] = 0;
        end
      end
    end else if (abort) m_busy[k] = 1'b0;
    else if (grant) begin
      m_idx[k]++;
      if (m_idx[k] == 2 * m_len[k]) begin
        m_busy[k] = 1'b0;
        m_done[k] = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model(0);
    model(1);
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    cyc();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  function automatic logic [7:0] am(input int k, input logic [7:0] a);
    return k ? amem1[a] : amem0[a];
  endfunction

  task automatic mem_cmp(input string nm);
    for (int k = 0; k < 2; k++) begin
      int nb = 0;
      for (int a = 0; a < 256; a++) if (am(k, 8'(a)) !== rmem[k][a]) nb++;
      chk(nm, k, nb, 0);
    end
  endtask

  task automatic run_job(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                         output int busy_n, output int done_at, output int wr_n);
    src = s; dst = d; len = l; start = 1'b1;
    cyc();
    start = 1'b0;
    busy_n = 0; done_at = -1; wr_n = 0;
    for (int c = 1; c <= 100 && done_at < 0; c++) begin
      #1;
      if (o1.busy) busy_n++;
      if (o1.wr) wr_n++;
      if (o1.done) done_at = c;
      cyc();
    end
  endtask

  typedef struct {logic [7:0] s, d, l; int e_busy, e_done, e_wr;} job_t;
  job_t jobs [5];

  initial begin
    int bn, da, wn, nw0, nw1, fw, lw, bz0, d0, d1, nd;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    src = '0; dst = '0; len = '0; cpu_addr = '0; cpu_wdata = '0;
    jobs[0] = '{8'h10, 8'h40, 8'd4, 8, 9, 4};
    jobs[1] = '{8'h55, 8'h66, 8'd0, 0, 1, 0};
    jobs[2] = '{8'hFE, 8'hFF, 8'd3, 6, 7, 3};
    jobs[3] = '{8'h80, 8'hA0, 8'd1, 2, 3, 1};
    jobs[4] = '{8'hC0, 8'hC8, 8'd16, 32, 33, 16};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", 0, o0.busy, 0); chk("rst_done", 0, o0.done, 0); chk("rst_wr", 0, o0.wr, 0);
    chk("rst_busy", 1, o1.busy, 0); chk("rst_done", 1, o1.done, 0); chk("rst_wr", 1, o1.wr, 0);
    chk("rst_rd", 1, o1.rd, 0); chk("rst_wait", 1, o1.wt, 0);
    for (int a = 0; a < 256; a++) cpu_wr(8'(a), 8'($urandom));
    for (int i = 0; i < 4; i++) cpu_wr(8'h10 + 8'(i), 8'hA1 + 8'(i));
    cpu_wr(8'hFE, 8'h11); cpu_wr(8'hFF, 8'h22); cpu_wr(8'h00, 8'h33);
    mem_cmp("preload_image");

    for (int i = 0; i < 5; i++) begin
      run_job(jobs[i].s, jobs[i].d, jobs[i].l, bn, da, wn);
      chk("job_busy_cycles", i, bn, jobs[i].e_busy);
      chk("job_done_at", i, da, jobs[i].e_done);
      chk("job_writes", i, wn, jobs[i].e_wr);
    end
    for (int i = 0; i < 4; i++) chk("copy_data", i, amem1[8'h40 + 8'(i)], 8'hA1 + i);
    chk("overlap_ff", 0, amem1[8'hFF], 8'h11);
    chk("overlap_00", 0, amem1[8'h00], 8'h11);
    chk("overlap_01", 0, amem1[8'h01], 8'h11);
    mem_cmp("table_image");

    // CPU holds the port throughout: limit 4 wins every 5th cycle, limit 0 never moves
    src = 8'h20; dst = 8'h30; len = 8'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    nw0 = 0; nw1 = 0; fw = -1; lw = -1; bz0 = 0; d1 = -1;
    for (int c = 1; c <= 100 && d1 < 0; c++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'($urandom);
      #1;
      if (o1.wt) begin nw1++; lw = c; if (fw < 0) fw = c; end
      if (o0.wt) nw0++;
      if (o0.busy) bz0++;
      if (o1.done) d1 = c;
      cyc();
    end
    chk("starve_done_at", 1, d1, 31);
    chk("starve_waits", 1, nw1, 6);
    chk("starve_first_wait", 1, fw, 5);
    chk("starve_last_wait", 1, lw, 30);
    chk("prio_waits", 0, nw0, 0);
    chk("prio_frozen_busy", 0, bz0, 31);
    cpu_req = 1'b0;
    d0 = -1;
    for (int c = 1; c <= 40 && d0 < 0; c++) begin
      #1;
      if (o0.done) d0 = c;
      cyc();
    end
    chk("prio_resume_done", 0, d0, 7);

    // CPU requests for 20 cycles then releases
    src = 8'h50; dst = 8'h58; len = 8'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    nw0 = 0; nw1 = 0; bz0 = 0; d0 = -1; d1 = -1;
    for (int c = 1; c <= 60 && (d0 < 0 || d1 < 0); c++) begin
      cpu_req = c <= 20; cpu_we = 1'b0; cpu_addr = 8'($urandom);
      #1;
      if (o0.wt) nw0++;
      if (o1.wt) nw1++;
      if (c <= 20 && o0.busy) bz0++;
      if (o0.done) d0 = c;
      if (o1.done) d1 = c;
      cyc();
    end
    cpu_req = 1'b0;
    chk("hold20_waits", 0, nw0, 0);
    chk("hold20_busy", 0, bz0, 20);
    chk("hold20_done_at", 0, d0, 27);
    chk("hold20_waits", 1, nw1, 4);
    chk("hold20_done_at", 1, d1, 23);
    mem_cmp("contention_image");

    // Abort during the write of byte 2 of 4
    for (int i = 0; i < 4; i++) begin
      cpu_wr(8'h70 + 8'(i), 8'h5A + 8'(i));
      cpu_wr(8'h90 + 8'(i), 8'h00);
      cpu_wr(8'hB0 + 8'(i), 8'h00);
    end
    src = 8'h70; dst = 8'h90; len = 8'd4; start = 1'b1;
    cyc();
    start = 1'b0;
    nd = 0;
    for (int c = 1; c <= 8; c++) begin
      abort = c == 4;
      #1;
      if (c == 4) begin
        chk("abort_busy", 1, o1.busy, 1);
        chk("abort_no_rd", 1, o1.rd, 0);
        chk("abort_no_wr", 1, o1.wr, 0);
      end
      if (c == 5) chk("abort_busy_after", 1, o1.busy, 0);
      if (o1.done) nd++;
      cyc();
    end
    abort = 1'b0;
    chk("abort_no_done", 1, nd, 0);
    chk("abort_byte1", 1, amem1[8'h90], 8'h5A);
    chk("abort_byte2", 1, amem1[8'h91], 8'h00);

    // Reset during the write of byte 2 of 4
    src = 8'h70; dst = 8'hB0; len = 8'd4; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      rst = c == 4;
      #1;
      if (c == 4) chk("rst_no_wr", 1, o1.wr, 0);
      if (c == 5)
        for (int k = 0; k < 2; k++) begin
          obs_t o;
          o = k ? o1 : o0;
          chk("rst_mid_busy", k, o.busy, 0);
          chk("rst_mid_done", k, o.done, 0);
          chk("rst_mid_rd", k, o.rd, 0);
          chk("rst_mid_wr", k, o.wr, 0);
          chk("rst_mid_wait", k, o.wt, 0);
        end
      cyc();
    end
    rst = 1'b0;
    chk("rst_byte1", 1, amem1[8'hB0], 8'h5A);
    chk("rst_byte2", 1, amem1[8'hB1], 8'h00);

    // Start and abort together in IDLE: abort wins
    src = 8'h01; dst = 8'h02; len = 8'd2; start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    #1;
    chk("start_abort_busy", 1, o1.busy, 0);
    chk("start_abort_done", 1, o1.done, 0);
    mem_cmp("directed_image");

    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 299) == 0;
      start = $urandom_range(0, 7) == 0;
      abort = $urandom_range(0, 39) == 0;
      src = 8'($urandom); dst = 8'($urandom); len = 8'($urandom_range(0, 6));
      cpu_req = $urandom_range(0, 9) < 4; cpu_we = $urandom_range(0, 2) == 0;
      cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
      cyc();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (40) cyc();
    mem_cmp("random_image");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
